// File: rtl/calc_arbiter_pkg.sv
// Shared definitions for the calculator arbiter: widths, opcodes, FSM states.
package calc_arbiter_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int OP_W_DEF   = 3;
  localparam int OUT_W_DEF  = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // state   | meaning
  // IDLE    | waiting for a request, arbiter picks one
  // EXEC    | calculator inputs held, settle counter running
  // RESP    | result captured, waiting for owner rsp_ready
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A settle time of zero still needs one cycle for the inputs to reach the calculator.
  function automatic int settle_eff(input int s);
    return (s < 1) ? 1 : s;
  endfunction

endpackage

// File: rtl/calc_arbiter_if.sv
// Requester, response and calculator-side signals of the arbiter as one bundle.
interface calc_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int OUT_W  = 8
);
  logic              r0_valid, r1_valid;
  logic              r0_ready, r1_ready;
  logic [DATA_W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [OP_W-1:0]   r0_oper, r1_oper;
  logic              r0_rsp_valid, r1_rsp_valid;
  logic              r0_rsp_ready, r1_rsp_ready;
  logic [OUT_W-1:0]  rsp_out;
  logic [DATA_W-1:0] calc_a, calc_b;
  logic [OP_W-1:0]   calc_oper;
  logic [OUT_W-1:0]  calc_out;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  r0_valid, r1_valid, r0_a, r0_b, r1_a, r1_b, r0_oper, r1_oper,
           r0_rsp_ready, r1_rsp_ready, calc_out,
    output r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rsp_out,
           calc_a, calc_b, calc_oper, busy, grant_id
  );

  modport master (
    output r0_valid, r1_valid, r0_a, r0_b, r1_a, r1_b, r0_oper, r1_oper,
           r0_rsp_ready, r1_rsp_ready, calc_out,
    input  r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rsp_out,
           calc_a, calc_b, calc_oper, busy, grant_id
  );
endinterface

// File: rtl/calc_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the
// requester that was not served last (last=1 means r1 was served last).
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Grant is one-hot or zero by construction.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin scheduler sharing one combinational calculator between two requesters.
module calc_arbiter
  import calc_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SETTLE = 1
) (
  input logic           clk,
  input logic           rst_n,
  calc_arbiter_if.slave bus
);

  localparam int SETTLE_EFF = settle_eff(SETTLE);
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

  state_t            state, state_nxt;
  logic [1:0]        gnt;
  logic              last_served;
  logic              owner;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              rsp_hs;
  logic [DATA_W-1:0] calc_a_q, calc_b_q;
  logic [OP_W-1:0]   calc_oper_q;
  logic [OUT_W-1:0]  rsp_out_q;
  logic              r0_ready_c, r1_ready_c, r0_rsp_valid_c, r1_rsp_valid_c;

  rr_arbiter2 u_arb (
    .req  ({bus.r1_valid, bus.r0_valid}),
    .last (last_served),
    .gnt  (gnt)
  );

  assign accept = (state == ST_IDLE) && (gnt != 2'b00);
  assign rsp_hs = (state == ST_RESP) && (owner ? bus.r1_rsp_ready : bus.r0_rsp_ready);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt      = state;
    r0_ready_c     = 1'b0;
    r1_ready_c     = 1'b0;
    r0_rsp_valid_c = 1'b0;
    r1_rsp_valid_c = 1'b0;
    case (state)
      ST_IDLE: begin
        r0_ready_c = gnt[0];
        r1_ready_c = gnt[1];
        if (accept) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt == '0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        r0_rsp_valid_c = ~owner;
        r1_rsp_valid_c = owner;
        if (rsp_hs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Payload capture, settle countdown, result capture and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_a_q    <= '0;
      calc_b_q    <= '0;
      calc_oper_q <= '0;
      owner       <= 1'b0;
      cnt         <= '0;
      rsp_out_q   <= '0;
      last_served <= 1'b1;
    end else begin
      if (accept) begin
        calc_a_q    <= gnt[1] ? bus.r1_a    : bus.r0_a;
        calc_b_q    <= gnt[1] ? bus.r1_b    : bus.r0_b;
        calc_oper_q <= gnt[1] ? bus.r1_oper : bus.r0_oper;
        owner       <= gnt[1];
        cnt         <= CNT_W'(SETTLE_EFF - 1);
      end
      if (state == ST_EXEC) begin
        if (cnt == '0) rsp_out_q <= bus.calc_out;
        else           cnt       <= cnt - 1'b1;
      end
      if (rsp_hs) last_served <= owner;
    end
  end

  assign bus.r0_ready     = r0_ready_c;
  assign bus.r1_ready     = r1_ready_c;
  assign bus.r0_rsp_valid = r0_rsp_valid_c;
  assign bus.r1_rsp_valid = r1_rsp_valid_c;
  assign bus.rsp_out      = rsp_out_q;
  assign bus.calc_a       = calc_a_q;
  assign bus.calc_b       = calc_b_q;
  assign bus.calc_oper    = calc_oper_q;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.grant_id     = owner;

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter: a SETTLE=1 and a SETTLE=3 instance.
module tb_calc_arbiter;
  import calc_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_arbiter_if u_if ();
  calc_arbiter_if u_if3 ();

  calc_arbiter #(.SETTLE(1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
  calc_arbiter #(.SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(u_if3.slave));

  int checks = 0;
  int errors = 0;

  logic       use_model;
  logic [7:0] forced1;
  logic [7:0] forced3;

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      OP_ADD:  return 8'(a) + 8'(b);
      OP_SUB:  return 8'(a) - 8'(b);
      OP_MUL:  return 8'(a) * 8'(b);
      OP_AND:  return {4'b0, a & b};
      OP_OR:   return {4'b0, a | b};
      OP_XOR:  return {4'b0, a ^ b};
      OP_NOT:  return {4'b0, ~a};
      default: return {4'b0, a};
    endcase
  endfunction

  assign u_if.calc_out  = use_model ? model(u_if.calc_a, u_if.calc_b, u_if.calc_oper) : forced1;
  assign u_if3.calc_out = forced3;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic       v0;
    logic [3:0] a0, b0;
    logic [2:0] o0;
    logic       v1;
    logic [3:0] a1, b1;
    logic [2:0] o1;
    logic       gnt;
    logic [7:0] out;
  } vec_t;

  vec_t vecs[6];

  task automatic clear_inputs();
    u_if.r0_valid = 0; u_if.r1_valid = 0;
    u_if.r0_a = 0; u_if.r0_b = 0; u_if.r0_oper = 0;
    u_if.r1_a = 0; u_if.r1_b = 0; u_if.r1_oper = 0;
    u_if.r0_rsp_ready = 0; u_if.r1_rsp_ready = 0;
    u_if3.r0_valid = 0; u_if3.r1_valid = 0;
    u_if3.r0_a = 0; u_if3.r0_b = 0; u_if3.r0_oper = 0;
    u_if3.r1_a = 0; u_if3.r1_b = 0; u_if3.r1_oper = 0;
    u_if3.r0_rsp_ready = 0; u_if3.r1_rsp_ready = 0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(u_if.busy), 0);
    chk({tag, "_gid"}, 32'(u_if.grant_id), 0);
    chk({tag, "_rsp_out"}, 32'(u_if.rsp_out), 0);
    chk({tag, "_calc"}, {u_if.calc_a, u_if.calc_b, u_if.calc_oper}, 0);
    chk({tag, "_rspv"}, {u_if.r0_rsp_valid, u_if.r1_rsp_valid}, 0);
    chk({tag, "_busy3"}, 32'(u_if3.busy), 0);
    chk({tag, "_rspv3"}, {u_if3.r0_rsp_valid, u_if3.r1_rsp_valid}, 0);
    chk({tag, "_calc3"}, {u_if3.calc_a, u_if3.calc_b, u_if3.calc_oper}, 0);
  endtask

  initial begin
    int acc_cnt;
    int last_acc;
    int bad_gap;
    int r0_activity;

    use_model = 1; forced1 = 0; forced3 = 0;
    clear_inputs();

    vecs[0] = '{1, 4'b1001, 4'b0011, OP_ADD, 0, 4'h0, 4'h0, OP_ADD, 0, 8'd12};
    vecs[1] = '{1, 4'b0111, 4'b0010, OP_SUB, 1, 4'b0010, 4'b0011, OP_MUL, 1, 8'd6};
    vecs[2] = '{1, 4'b0111, 4'b0010, OP_SUB, 1, 4'b0010, 4'b0011, OP_MUL, 0, 8'd5};
    vecs[3] = '{1, 4'b0111, 4'b0010, OP_SUB, 1, 4'b0010, 4'b0011, OP_MUL, 1, 8'd6};
    vecs[4] = '{0, 4'h0, 4'h0, OP_ADD, 1, 4'b1100, 4'b1010, OP_AND, 1, 8'd8};
    vecs[5] = '{1, 4'b0101, 4'b0000, OP_NOT, 0, 4'h0, 4'h0, OP_ADD, 0, 8'd10};

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    chk("reset_ready", {u_if.r0_ready, u_if.r1_ready}, 0);
    rst_n = 1;

    // Table-driven single transactions on the SETTLE=1 instance
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      u_if.r0_valid = vecs[i].v0; u_if.r0_a = vecs[i].a0; u_if.r0_b = vecs[i].b0; u_if.r0_oper = vecs[i].o0;
      u_if.r1_valid = vecs[i].v1; u_if.r1_a = vecs[i].a1; u_if.r1_b = vecs[i].b1; u_if.r1_oper = vecs[i].o1;
      #1;
      chk($sformatf("v%0d_ready", i), {u_if.r1_ready, u_if.r0_ready}, vecs[i].gnt ? 2'b10 : 2'b01);
      @(negedge clk);
      u_if.r0_valid = 0; u_if.r1_valid = 0;
      chk($sformatf("v%0d_busy", i), 32'(u_if.busy), 1);
      chk($sformatf("v%0d_exec_ready", i), {u_if.r1_ready, u_if.r0_ready}, 0);
      chk($sformatf("v%0d_gid", i), 32'(u_if.grant_id), 32'(vecs[i].gnt));
      chk($sformatf("v%0d_calc", i), {u_if.calc_a, u_if.calc_b, u_if.calc_oper},
          vecs[i].gnt ? {vecs[i].a1, vecs[i].b1, vecs[i].o1} : {vecs[i].a0, vecs[i].b0, vecs[i].o0});
      @(negedge clk);
      chk($sformatf("v%0d_rspv", i), {u_if.r1_rsp_valid, u_if.r0_rsp_valid}, vecs[i].gnt ? 2'b10 : 2'b01);
      chk($sformatf("v%0d_rsp_out", i), 32'(u_if.rsp_out), 32'(vecs[i].out));
      if (vecs[i].gnt) u_if.r1_rsp_ready = 1; else u_if.r0_rsp_ready = 1;
      @(negedge clk);
      chk($sformatf("v%0d_done", i), {u_if.busy, u_if.r1_rsp_valid, u_if.r0_rsp_valid}, 0);
      u_if.r0_rsp_ready = 0; u_if.r1_rsp_ready = 0;
    end

    // Response hold-off: r0 owner stalls, calc_out moves, non-owner rsp_ready and r1_valid ignored
    use_model = 0; forced1 = 8'h21;
    @(negedge clk);
    u_if.r0_valid = 1; u_if.r0_a = 4'h3; u_if.r0_b = 4'h4; u_if.r0_oper = OP_PASS;
    @(negedge clk);
    u_if.r0_valid = 0;
    @(negedge clk);
    u_if.r1_valid = 1; u_if.r1_rsp_ready = 1;
    for (int k = 0; k < 5; k++) begin
      forced1 = 8'h40 + 8'(k);
      #1;
      chk($sformatf("hold%0d", k), {u_if.r0_rsp_valid, u_if.r1_rsp_valid, u_if.r0_ready, u_if.r1_ready, u_if.rsp_out},
          {4'b1000, 8'h21});
      @(negedge clk);
    end
    u_if.r1_rsp_ready = 0; u_if.r0_rsp_ready = 1;
    @(negedge clk);
    chk("hold_release_idle", {u_if.busy, u_if.r0_rsp_valid}, 0);
    chk("hold_release_r1_ready", 32'(u_if.r1_ready), 1);
    u_if.r1_valid = 0; u_if.r0_rsp_ready = 0;
    use_model = 1;

    // SETTLE=3 instance: latency and late calc_out change
    forced3 = 8'd5;
    @(negedge clk);
    u_if3.r0_valid = 1; u_if3.r0_a = 4'h1; u_if3.r0_b = 4'h2; u_if3.r0_oper = OP_ADD;
    #1 chk("s3_ready", 32'(u_if3.r0_ready), 1);
    @(negedge clk);
    u_if3.r0_valid = 0;
    chk("s3_t1", {u_if3.busy, u_if3.r0_rsp_valid}, 2'b10);
    @(negedge clk);
    forced3 = 8'd9;
    chk("s3_t2", {u_if3.busy, u_if3.r0_rsp_valid}, 2'b10);
    @(negedge clk);
    chk("s3_t3", {u_if3.busy, u_if3.r0_rsp_valid}, 2'b10);
    @(negedge clk);
    chk("s3_rspv", {u_if3.r0_rsp_valid, u_if3.r1_rsp_valid}, 2'b10);
    chk("s3_rsp_out", 32'(u_if3.rsp_out), 9);
    u_if3.r0_rsp_ready = 1;
    @(negedge clk);
    u_if3.r0_rsp_ready = 0;
    chk("s3_done", 32'(u_if3.busy), 0);

    // Reset mid-EXEC; the SETTLE=1 pointer currently favours r1 and must return to r0
    @(negedge clk);
    u_if3.r1_valid = 1; u_if3.r1_a = 4'h7; u_if3.r1_b = 4'h1; u_if3.r1_oper = OP_OR;
    @(negedge clk);
    u_if3.r1_valid = 0;
    chk("rst_pre_exec", 32'(u_if3.busy), 1);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    check_idle_zero("rst_mid");
    rst_n = 1;
    @(negedge clk);
    u_if.r0_valid = 1; u_if.r0_a = 4'h2; u_if.r0_b = 4'h2; u_if.r0_oper = OP_MUL;
    u_if.r1_valid = 1; u_if.r1_a = 4'h1; u_if.r1_b = 4'h1; u_if.r1_oper = OP_ADD;
    #1 chk("rst_after_grant", {u_if.r1_ready, u_if.r0_ready}, 2'b01);
    chk("rst_after_no_rsp3", {u_if3.busy, u_if3.r0_rsp_valid, u_if3.r1_rsp_valid}, 0);
    @(negedge clk);
    u_if.r0_valid = 0; u_if.r1_valid = 0;
    @(negedge clk);
    chk("rst_after_rsp", {u_if.r0_rsp_valid, u_if.rsp_out}, {1'b1, 8'd4});
    u_if.r0_rsp_ready = 1;
    @(negedge clk);
    u_if.r0_rsp_ready = 0;

    // r1 back-to-back with rsp_ready high: one acceptance every 3 cycles
    @(negedge clk);
    u_if.r1_valid = 1; u_if.r1_a = 4'h5; u_if.r1_b = 4'h3; u_if.r1_oper = OP_XOR;
    u_if.r1_rsp_ready = 1;
    acc_cnt = 0; last_acc = -3; bad_gap = 0; r0_activity = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (u_if.r1_ready) begin
        if (c - last_acc != 3) bad_gap++;
        last_acc = c;
        acc_cnt++;
      end
      if (u_if.r0_ready || u_if.r0_rsp_valid) r0_activity++;
      @(negedge clk);
    end
    u_if.r1_valid = 0;
    chk("b2b_accepts", 32'(acc_cnt), 4);
    chk("b2b_gaps", 32'(bad_gap), 0);
    chk("b2b_r0_quiet", 32'(r0_activity), 0);
    chk("b2b_rsp_out", 32'(u_if.rsp_out), 6);
    @(negedge clk);
    u_if.r1_rsp_ready = 0;
    chk("b2b_idle", 32'(u_if.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
